// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer driving a 2-to-4 decoder (E, S, A) with dwell and blanking.
// Optional pause input enabled by defining DECSCAN_PAUSE_EN.
module decoder_scan_sequencer #(
   parameter int DWELL_W = 16,
   parameter int BLANK_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
`ifdef DECSCAN_PAUSE_EN
   input  logic               pause,
`endif
   input  logic               mode_cont,
   input  logic               pol_in,
   input  logic [3:0]         code_mask,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [BLANK_W-1:0] blank,
   output logic               dec_e,
   output logic               dec_s,
   output logic [1:0]         dec_a,
   output logic               busy,
   output logic               step_tick,
   output logic               done
);

`ifndef DECSCAN_PAUSE_EN
   logic pause;
   assign pause = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;

   state_t             state;
   logic               mode_q;
   logic [3:0]         mask_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [BLANK_W-1:0] blank_q;
   logic [DWELL_W-1:0] dcnt;
   logic [BLANK_W-1:0] bcnt;

   logic [1:0]         first_a;
   logic [1:0]         nxt_a;
   logic               higher;
   logic [DWELL_W-1:0] dload_in;
   logic [DWELL_W-1:0] dload_q;

   // Dwell of 0 behaves as 1, so the reload value is max(dwell,1)-1.
   assign dload_in = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
   assign dload_q  = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);

   always_comb begin
      first_a = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (code_mask[i]) first_a = 2'(i);
   end

   // Nearest set bit above dec_a with wrap; falls back to dec_a itself.
   always_comb begin
      nxt_a  = dec_a;
      higher = 1'b0;
      for (int i = 3; i >= 1; i--)
         if (mask_q[dec_a + 2'(i)]) nxt_a = dec_a + 2'(i);
      for (int j = 0; j < 4; j++)
         if (mask_q[j] && (2'(j) > dec_a)) higher = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mode_q    <= 1'b0;
         mask_q    <= '0;
         dwell_q   <= '0;
         blank_q   <= '0;
         dcnt      <= '0;
         bcnt      <= '0;
         dec_e     <= 1'b0;
         dec_s     <= 1'b0;
         dec_a     <= 2'd0;
         busy      <= 1'b0;
         step_tick <= 1'b0;
         done      <= 1'b0;
      end else begin
         step_tick <= 1'b0;
         done      <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start && !stop) begin
                  if (code_mask != 4'd0) begin
                     mode_q    <= mode_cont;
                     mask_q    <= code_mask;
                     dwell_q   <= dwell;
                     blank_q   <= blank;
                     dec_s     <= pol_in;
                     dec_a     <= first_a;
                     dcnt      <= dload_in;
                     dec_e     <= 1'b1;
                     busy      <= 1'b1;
                     step_tick <= 1'b1;
                     state     <= DWELL;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            DWELL: begin
               if (stop) begin
                  state <= IDLE;
                  dec_e <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (pause) begin
                  state <= DWELL;
               end else if (dcnt != '0) begin
                  dcnt <= dcnt - DWELL_W'(1);
               end else if (!mode_q && !higher) begin
                  state <= IDLE;
                  dec_e <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (blank_q != '0) begin
                  state <= BLANK;
                  dec_e <= 1'b0;
                  bcnt  <= blank_q - BLANK_W'(1);
               end else begin
                  dec_a     <= nxt_a;
                  dcnt      <= dload_q;
                  step_tick <= 1'b1;
               end
            end
            BLANK: begin
               if (stop) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (pause) begin
                  state <= BLANK;
               end else if (bcnt != '0) begin
                  bcnt <= bcnt - BLANK_W'(1);
               end else begin
                  state     <= DWELL;
                  dec_a     <= nxt_a;
                  dcnt      <= dload_q;
                  dec_e     <= 1'b1;
                  step_tick <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench for decoder_scan_sequencer: trace-level model of the scan schedule.
// The pause scenario is exercised when DECSCAN_PAUSE_EN is defined.
module tb_decoder_scan_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, stop, mode_cont, pol_in;
   logic [3:0]  code_mask;
   logic [15:0] dwell;
   logic [7:0]  blank;
   logic        dec_e, dec_s, busy, step_tick, done;
   logic [1:0]  dec_a;
`ifdef DECSCAN_PAUSE_EN
   logic        pause = 1'b0;
`endif

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic       e;
      logic [1:0] a;
      logic       busy;
      logic       tick;
      logic       done;
   } obs_t;

   obs_t       exp_q[$];
   logic [1:0] last_a = 2'd0;
   logic       last_s = 1'b0;

   always #5 clk = ~clk;

   decoder_scan_sequencer #(.DWELL_W(16), .BLANK_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
`ifdef DECSCAN_PAUSE_EN
      .pause(pause),
`endif
      .mode_cont(mode_cont), .pol_in(pol_in), .code_mask(code_mask),
      .dwell(dwell), .blank(blank), .dec_e(dec_e), .dec_s(dec_s),
      .dec_a(dec_a), .busy(busy), .step_tick(step_tick), .done(done)
   );

   // Expected per-cycle trace, starting with the cycle after start is sampled.
   task automatic build(input logic [3:0] m, input int dw, input int bl,
                        input logic cont, input int stop_at);
      int codes[$];
      int dwn;
      exp_q.delete();
      dwn = (dw == 0) ? 1 : dw;
      if (m == 4'd0) begin
         exp_q.push_back('{1'b0, last_a, 1'b0, 1'b0, 1'b1});
         return;
      end
      for (int r = 0; r < (cont ? 40 : 1); r++)
         for (int k = 0; k < 4; k++)
            if (m[k]) codes.push_back(k);
      foreach (codes[j]) begin
         for (int c = 0; c < dwn; c++)
            exp_q.push_back('{1'b1, 2'(codes[j]), 1'b1, c == 0, 1'b0});
         if (j != codes.size() - 1)
            for (int c = 0; c < bl; c++)
               exp_q.push_back('{1'b0, 2'(codes[j]), 1'b1, 1'b0, 1'b0});
         if (cont && exp_q.size() > 40) break;
      end
      if (!cont)
         exp_q.push_back('{1'b0, 2'(codes[codes.size()-1]), 1'b0, 1'b0, 1'b1});
      if (stop_at > 0 && stop_at < exp_q.size()) begin
         logic [1:0] ha;
         ha = exp_q[stop_at-1].a;
         while (exp_q.size() > stop_at) void'(exp_q.pop_back());
         exp_q.push_back('{1'b0, ha, 1'b0, 1'b0, 1'b1});
      end
   endtask

   task automatic run_scan(input string nm, input logic [3:0] m, input int dw,
                           input int bl, input logic cont, input logic pol,
                           input int stop_at);
      obs_t got, idle;
      logic exp_s;
      build(m, dw, bl, cont, stop_at);
      exp_s = (m != 4'd0) ? pol : last_s;
      @(negedge clk);
      start = 1'b1; stop = 1'b0; code_mask = m;
      dwell = 16'(dw); blank = 8'(bl); mode_cont = cont; pol_in = pol;
      foreach (exp_q[i]) begin
         @(negedge clk);
         got = '{dec_e, dec_a, busy, step_tick, done};
         tests++;
         if (got !== exp_q[i] || dec_s !== exp_s) begin
            fails++;
            $display("FAIL %s cyc %0d: got e/a/busy/tick/done=%b s=%b, want %b s=%b",
                     nm, i + 1, got, dec_s, exp_q[i], exp_s);
         end
         start = exp_q[i].busy ? 1'($urandom_range(0, 1)) : 1'b0;
         stop = (i == stop_at - 1);
         code_mask = 4'($urandom);
         dwell = 16'($urandom_range(0, 4));
         blank = 8'($urandom_range(0, 3));
         mode_cont = 1'($urandom);
         pol_in = 1'($urandom);
      end
      stop = 1'b0;
      idle = '{1'b0, exp_q[exp_q.size()-1].a, 1'b0, 1'b0, 1'b0};
      @(negedge clk);
      got = '{dec_e, dec_a, busy, step_tick, done};
      tests++;
      if (got !== idle || dec_s !== exp_s) begin
         fails++;
         $display("FAIL %s idle: got %b s=%b, want %b s=%b", nm, got, dec_s, idle, exp_s);
      end
      last_a = idle.a;
      last_s = exp_s;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode_cont = 1'b0;
      pol_in = 1'b0; code_mask = 4'd0; dwell = '0; blank = '0;
      repeat (2) @(negedge clk);
      tests++;
      if ({dec_e, dec_s, dec_a, busy, step_tick, done} !== 7'd0) begin
         fails++;
         $display("FAIL reset: got %b, want 0000000",
                  {dec_e, dec_s, dec_a, busy, step_tick, done});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      run_scan("single_full", 4'b1111, 3, 2, 1'b0, 1'b1, 0);
      run_scan("cont_b2b", 4'b1010, 1, 0, 1'b1, 1'b0, 9);
      run_scan("stop_code1", 4'b1111, 3, 2, 1'b0, 1'b1, 7);
      run_scan("restart", 4'b1111, 3, 2, 1'b0, 1'b0, 0);
      run_scan("empty_mask", 4'b0000, 3, 2, 1'b0, 1'b1, 0);
      run_scan("dwell_zero", 4'b0001, 0, 0, 1'b0, 1'b1, 0);
      run_scan("one_bit_cont", 4'b0100, 2, 1, 1'b1, 1'b1, 8);
      run_scan("stop_blank", 4'b0011, 2, 3, 1'b0, 1'b0, 4);
   endtask

   task automatic test_start_stop_idle();
      @(negedge clk);
      start = 1'b1; stop = 1'b1; code_mask = 4'b1111; dwell = 16'd2;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests++;
         if (busy !== 1'b0 || done !== 1'b0 || dec_e !== 1'b0) begin
            fails++;
            $display("FAIL start_stop_idle cyc %0d: busy=%b done=%b e=%b, want 0 0 0",
                     i, busy, done, dec_e);
         end
      end
      start = 1'b0; stop = 1'b0;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      start = 1'b1; code_mask = 4'b0110; dwell = 16'd10; pol_in = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({dec_e, dec_s, dec_a, busy, step_tick, done} !== 7'd0) begin
         fails++;
         $display("FAIL async_reset: got %b, want 0000000",
                  {dec_e, dec_s, dec_a, busy, step_tick, done});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL async_reset_after: done=%b busy=%b, want 0 0", done, busy);
      end
      last_a = 2'd0;
      last_s = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 25; n++) begin
         logic [3:0] m;
         int dw, bl, sa, len;
         logic cont, pol;
         m = 4'($urandom);
         dw = $urandom_range(0, 4);
         bl = $urandom_range(0, 3);
         cont = 1'($urandom);
         pol = 1'($urandom);
         build(m, dw, bl, cont, 0);
         len = exp_q.size();
         if (m == 4'd0) sa = 0;
         else if (cont) sa = $urandom_range(1, 30);
         else if (len > 1 && $urandom_range(0, 1) == 1) sa = $urandom_range(1, len - 1);
         else sa = 0;
         run_scan("random", m, dw, bl, cont, pol, sa);
      end
   endtask

`ifdef DECSCAN_PAUSE_EN
   task automatic test_pause();
      int ecnt, tcnt, dcnt;
      ecnt = 0; tcnt = 0; dcnt = 0;
      @(negedge clk);
      start = 1'b1; stop = 1'b0; code_mask = 4'b0001; dwell = 16'd3;
      blank = 8'd0; mode_cont = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         start = 1'b0;
         ecnt += int'(dec_e);
         tcnt += int'(step_tick);
         dcnt += int'(done);
         if (dec_e && dec_a !== 2'd0) begin
            tests++;
            fails++;
            $display("FAIL pause_addr cyc %0d: a=%0d, want 0", c, dec_a);
         end
         pause = (c >= 1 && c <= 4);
      end
      pause = 1'b0;
      tests++;
      if (ecnt != 7 || tcnt != 1 || dcnt != 1) begin
         fails++;
         $display("FAIL pause: e_cycles=%0d ticks=%0d dones=%0d, want 7 1 1",
                  ecnt, tcnt, dcnt);
      end
      last_a = 2'd0;
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_start_stop_idle();
      test_async_reset();
      test_random();
`ifdef DECSCAN_PAUSE_EN
      test_pause();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
